// File: rtl/psum_accum_if.sv
// Valid/ready stream bundle shared by the psum input and the finished-group output.
// The master drives vld/data; the slave drives rdy.
interface psum_accum_if #(
    parameter int unsigned DW = 288
) ();
    logic          vld;
    logic          rdy;
    logic [DW-1:0] data;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/psum_accum.sv
// Accumulates acc_len beats of LANES-wide partial sums, adds a per-group bias, applies optional
// ReLU and holds the result in a one-deep output register so the next group can proceed.
module psum_accum #(
    parameter int unsigned LANES = 9,
    parameter int unsigned PW    = 32,
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] acc_len_i,
    input  logic [PW-1:0]    bias_i,
    input  logic             relu_en_i,
    psum_accum_if.slave      in_if,
    psum_accum_if.master     out_if,
    output logic             busy_o
);

    typedef logic [LANES-1:0][PW-1:0] vec_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             relu_q, relu_d;
    vec_t             acc_q, acc_d;
    vec_t             out_data_q, out_data_d;
    logic             out_vld_q, out_vld_d;

    logic [CNT_W-1:0] eff_len, cur_len;
    logic             first, last, in_rdy, beat, relu_eff;
    vec_t             psum, sum, res;

    always_comb begin
        eff_len  = (acc_len_i == '0) ? CNT_W'(1) : acc_len_i;
        first    = (cnt_q == '0);
        cur_len  = first ? eff_len : len_q;
        last     = (cnt_q == cur_len - CNT_W'(1));
        // Only a final beat can stall, and only while an unaccepted result is held.
        in_rdy   = !last || !out_vld_q || out_if.rdy;
        beat     = in_if.vld && in_rdy;
        relu_eff = first ? relu_en_i : relu_q;
        psum     = in_if.data;
        sum      = '0;
        res      = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            sum[k] = (first ? bias_i : acc_q[k]) + psum[k];
            res[k] = (relu_eff && sum[k][PW-1]) ? '0 : sum[k];
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        relu_d     = relu_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q && !out_if.rdy;
        if (clr_i) begin
            cnt_d     = '0;
            acc_d     = '0;
            out_vld_d = 1'b0;
        end else if (beat) begin
            acc_d = sum;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
            if (first) begin
                len_d  = eff_len;
                relu_d = relu_en_i;
            end
            // A final beat reloads the output even when the old result leaves this cycle.
            if (last) begin
                out_data_d = res;
                out_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            len_q      <= '0;
            relu_q     <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            relu_q     <= relu_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign in_if.rdy   = in_rdy;
    assign out_if.vld  = out_vld_q;
    assign out_if.data = out_data_q;
    assign busy_o      = (cnt_q != '0);

endmodule
